// File: rtl/mem_port_initiator.sv
// -----------------------------------------------------------------------------
// mem_port_initiator
//   Core-side initiator for the shared data-memory request/grant bus. Turns a
//   MEM-stage load/store into a held bus request, stalls the pipeline until the
//   arbiter grants, and hands load data back. A grant timeout and an alignment
//   check keep a hung or misused bus from locking the core silently.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   mem_read_i          MEM-stage load request (level, held while stalled)
//   mem_write_i         MEM-stage store request (level, held while stalled)
//   addr_i, wdata_i     MEM-stage byte address and store data
//   stall_o             freeze pipeline (combinational)
//   rdata_o             load data, valid with done_o
//   done_o              1-cycle pulse: access finished, pipeline advances
//   err_timeout_o       sticky: a request was aborted on grant timeout
//   err_align_o         1-cycle pulse with done_o: misaligned access rejected
//   MemRequest          bus request to arbiter
//   MemRead, MemWrite   bus strobes
//   MemAddress          registered bus address
//   MemWriteData        registered bus write data
//   MemReadData         read data from arbiter, valid in the grant cycle
//   MemGrant            arbiter grant; access completes at the end of this cycle
// -----------------------------------------------------------------------------
module mem_port_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_timeout_o,
  output logic        err_align_o,
  output logic        MemRequest,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  input  logic        MemGrant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        op;
  logic        misaligned;
  logic        timeout_hit;
  logic [15:0] cnt;
  logic        rd_q;
  logic        wr_q;
  logic        align_q;

  assign op          = mem_read_i | mem_write_i;
  assign misaligned  = CHECK_ALIGN && (addr_i[1:0] != 2'b00);
  // Grant has priority: a timeout only counts in a cycle with no grant.
  assign timeout_hit = (state == REQ) && !MemGrant && (cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (op) state_nxt = misaligned ? DONE : REQ;
      REQ:  if (MemGrant || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: strobes are gated by REQ so reset drops the request at once.
  always_comb begin
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_align_o = 1'b0;
    MemRequest  = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    case (state)
      IDLE: stall_o = op;
      REQ: begin
        stall_o    = 1'b1;
        MemRequest = 1'b1;
        MemRead    = rd_q;
        MemWrite   = wr_q;
      end
      DONE: begin
        done_o      = 1'b1;
        err_align_o = align_q;
      end
      default: ;
    endcase
  end

  // Bus registers, timeout counter, return data and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemAddress    <= 32'd0;
      MemWriteData  <= 32'd0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      align_q       <= 1'b0;
      cnt           <= 16'd0;
      rdata_o       <= 32'd0;
      err_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            MemAddress   <= addr_i;
            MemWriteData <= wdata_i;
            // Store wins when both strobes are requested.
            wr_q         <= mem_write_i;
            rd_q         <= mem_read_i & ~mem_write_i;
            align_q      <= misaligned;
            cnt          <= 16'd0;
          end
        end
        REQ: begin
          if (MemGrant) begin
            if (rd_q) rdata_o <= MemReadData;
          end else if (timeout_hit) begin
            err_timeout_o <= 1'b1;
            rdata_o       <= 32'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
module tb_mem_port_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_timeout_o;
  logic        err_align_o;
  logic        MemRequest;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        MemGrant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_initiator #(
    .TIMEOUT_CYCLES(8),
    .CHECK_ALIGN   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .done_o       (done_o),
    .err_timeout_o(err_timeout_o),
    .err_align_o  (err_align_o),
    .MemRequest   (MemRequest),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData),
    .MemGrant     (MemGrant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one access from IDLE. gdelay = number of REQ cycles without grant
  // before the grant cycle (-1: never grant). Cycle 0 is the op cycle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rddata, input int gdelay,
                           input logic exp_rd, input logic exp_wr,
                           output int stall_n, output int req_n, output int done_n,
                           output int done_idx, output int unstable,
                           output logic [31:0] rdat, output logic eal);
    stall_n = 0; req_n = 0; done_n = 0; done_idx = -1; unstable = 0;
    rdat = 32'hx; eal = 1'bx;
    @(posedge clk); #1;
    mem_read_i = rd; mem_write_i = wr; addr_i = addr; wdata_i = wdata;
    MemGrant = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (stall_o) stall_n++;
      if (MemRequest) begin
        req_n++;
        if (MemAddress !== addr || MemWriteData !== wdata ||
            MemRead !== exp_rd || MemWrite !== exp_wr) unstable++;
        MemGrant    = (req_n - 1 == gdelay);
        MemReadData = rddata;
      end else begin
        MemGrant = 1'b0;
      end
      if (done_o) begin
        done_n++; done_idx = c; rdat = rdata_o; eal = err_align_o;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; MemGrant = 1'b0;
    @(negedge clk);
    if (done_o) done_n++;
  endtask

  int st, rq, dn, di, us;
  logic [31:0] rd_v;
  logic al;
  logic [5:0] pat;
  logic [31:0] last;

  initial begin
    rst = 1'b1; mem_read_i = 0; mem_write_i = 0; addr_i = 0; wdata_i = 0;
    MemReadData = 0; MemGrant = 0;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, MemRequest}, 32'd0);
    check("rst_done",  {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr",  MemAddress, 32'd0);
    check("rst_terr",  {31'd0, err_timeout_o}, 32'd0);
    rst = 1'b0;

    // Load, immediate grant
    do_access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0, st, rq, dn, di, us, rd_v, al);
    check("ld0_stall", st, 2);
    check("ld0_req",   rq, 1);
    check("ld0_done",  dn, 1);
    check("ld0_idx",   di, 2);
    check("ld0_rdata", rd_v, 32'hDEADBEEF);
    check("ld0_align", {31'd0, al}, 0);
    check("ld0_stable", us, 0);

    // Store, grant after 5 wait cycles
    do_access(0, 1, 32'h20, 32'h12345678, 32'hCAFEF00D, 5, 0, 1, st, rq, dn, di, us, rd_v, al);
    check("st_stall", st, 7);
    check("st_req",   rq, 6);
    check("st_done",  dn, 1);
    check("st_idx",   di, 7);
    check("st_rdata", rd_v, 32'hDEADBEEF);
    check("st_stable", us, 0);

    // Timeout with no grant
    do_access(1, 0, 32'h40, 32'h0, 32'h55555555, -1, 1, 0, st, rq, dn, di, us, rd_v, al);
    check("to_req",   rq, 8);
    check("to_stall", st, 9);
    check("to_done",  dn, 1);
    check("to_rdata", rd_v, 32'h0);
    check("to_err",   {31'd0, err_timeout_o}, 1);

    // Successful access afterwards; error stays sticky
    do_access(1, 0, 32'h44, 32'h0, 32'h0BADF00D, 1, 1, 0, st, rq, dn, di, us, rd_v, al);
    check("ld1_stall", st, 3);
    check("ld1_req",   rq, 2);
    check("ld1_rdata", rd_v, 32'h0BADF00D);
    check("ld1_terr",  {31'd0, err_timeout_o}, 1);

    // Misaligned load
    do_access(1, 0, 32'h13, 32'h0, 32'h77777777, 0, 1, 0, st, rq, dn, di, us, rd_v, al);
    check("mis_req",   rq, 0);
    check("mis_idx",   di, 1);
    check("mis_stall", st, 1);
    check("mis_align", {31'd0, al}, 1);
    check("mis_done",  dn, 1);

    // Read and write together: store wins
    do_access(1, 1, 32'h24, 32'hA5A5A5A5, 32'h99999999, 0, 0, 1, st, rq, dn, di, us, rd_v, al);
    check("rw_stable", us, 0);
    check("rw_req",    rq, 1);
    check("rw_rdata",  rd_v, 32'h0BADF00D);

    // Reset three cycles into REQ
    @(posedge clk); #1;
    mem_read_i = 1; addr_i = 32'h50;
    repeat (4) @(negedge clk);
    check("mr_pre_req", {31'd0, MemRequest}, 1);
    rst = 1'b1; #1;
    check("mr_req",   {31'd0, MemRequest}, 0);
    check("mr_addr",  MemAddress, 32'd0);
    check("mr_rdata", rdata_o, 32'd0);
    check("mr_terr",  {31'd0, err_timeout_o}, 0);
    mem_read_i = 0; #1;
    check("mr_stall", {31'd0, stall_o}, 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_o || MemRequest) dn++;
    end
    check("mr_quiet", dn, 0);
    rst = 1'b0;
    do_access(1, 0, 32'h60, 32'h0, 32'h31415926, 0, 1, 0, st, rq, dn, di, us, rd_v, al);
    check("mr_ld_rdata", rd_v, 32'h31415926);
    check("mr_ld_idx",   di, 2);

    // Back-to-back loads held continuously
    @(posedge clk); #1;
    mem_read_i = 1; addr_i = 32'h14; pat = 0; dn = 0; last = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = MemRequest;
      MemGrant = MemRequest;
      MemReadData = (c < 3) ? 32'h11111111 : 32'h22222222;
      if (done_o) begin dn++; last = rdata_o; end
    end
    @(posedge clk); #1;
    mem_read_i = 0; MemGrant = 0;
    check("b2b_pattern", {26'd0, pat}, 32'b010010);
    check("b2b_done",    dn, 2);
    check("b2b_rdata",   last, 32'h22222222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
